// File: rtl/int2float_pkg.sv
// int2float_pkg: shared widths, output record type and helpers for the
// integer-to-float pipeline.
package int2float_pkg;

  localparam int IN_W_DEF  = 11;
  localparam int EXP_W_DEF = 3;
  localparam int MAN_W_DEF = 4;
  localparam int OUT_W     = EXP_W_DEF + MAN_W_DEF;

  // {exp, man} with exp in the MSBs; the mantissa carries no hidden bit
  typedef struct packed {
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  // Width needed to hold a bit index into an n-bit word (at least 1)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int2float_lzc.sv
// int2float_lzc: leading-one detector. Reports the index of the most
// significant set bit of x, and a flag when x is all zeros.
module int2float_lzc
  import int2float_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0]        x,
  output logic [idx_w(IN_W)-1:0] msb,
  output logic                   zero
);

  localparam int P_W = idx_w(IN_W);

  // Scan upward so the highest set bit wins
  always_comb begin
    msb  = '0;
    zero = 1'b1;
    for (int i = 0; i < IN_W; i++) begin
      if (x[i]) begin
        msb  = P_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int2float_pipe.sv
// int2float_pipe: two-stage unsigned integer to {exp, man} converter with
// valid/ready handshake on both sides.
//   Stage 1: leading-one detect, capture word and MSB index.
//   Stage 2: shift, round, pack into the output register.
// Build option INT2FLOAT_RNE_EN: round-to-nearest-even on the discarded
// bits, with mantissa carry and exponent saturation. Without it, the
// discarded bits are truncated.
module int2float_pipe
  import int2float_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_data
);

  localparam int P_W     = idx_w(IN_W);
  localparam int X_W     = P_W + 2;
  localparam int MR_W    = MAN_W + 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  // The widest input must fit the exponent range without rounding help
  if (IN_W > MAN_W + EXP_MAX) begin : g_cfg_err
    $error("int2float_pipe: IN_W exceeds MAN_W + 2**EXP_W - 1");
  end

  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s1_advance;
  logic [IN_W-1:0]        s1_x;
  logic [P_W-1:0]         s1_msb;
  logic                   s1_zero;
  logic [P_W-1:0]         lzc_msb;
  logic                   lzc_zero;
  logic                   big;
  logic [X_W-1:0]         sh;
  logic [IN_W-1:0]        shifted;
  logic [EXP_W+MAN_W-1:0] result;

  int2float_lzc #(
    .IN_W (IN_W)
  ) u_lzc (
    .x    (in_data),
    .msb  (lzc_msb),
    .zero (lzc_zero)
  );

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  // Stage-2 alignment: shift amount equals the unrounded exponent
  always_comb begin
    big     = !s1_zero && (int'(s1_msb) >= MAN_W);
    sh      = big ? (X_W'(s1_msb) - X_W'(MAN_W - 1)) : '0;
    shifted = s1_x >> sh;
  end

`ifdef INT2FLOAT_RNE_EN
  logic [IN_W-1:0] rem;
  logic [IN_W-1:0] half;
  logic            round_up;
  logic [MR_W-1:0] man_rnd;
  logic [X_W-1:0]  exp_rnd;

  // Round to nearest-even, renormalise on carry, saturate past max exponent
  always_comb begin
    rem      = s1_x & ((IN_W'(1) << sh) - IN_W'(1));
    half     = big ? (IN_W'(1) << (sh - X_W'(1))) : '0;
    round_up = big && ((rem > half) || ((rem == half) && shifted[0]));
    man_rnd  = {1'b0, MAN_W'(shifted)} + MR_W'(round_up);
    exp_rnd  = sh;
    if (man_rnd[MAN_W]) begin
      man_rnd = MR_W'(1) << (MAN_W - 1);
      exp_rnd = sh + X_W'(1);
    end
    if (int'(exp_rnd) > EXP_MAX) begin
      result = '1;
    end else begin
      result = {EXP_W'(exp_rnd), MAN_W'(man_rnd)};
    end
  end
`else
  // Truncate: keep the top MAN_W bits, exponent is the shift amount
  always_comb begin
    result = {EXP_W'(sh), MAN_W'(shifted)};
  end
`endif

  // Control flops and output register; reset flushes every in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= result;
        end
      end
    end
  end

  // Stage-1 data capture; held while the stage is stalled
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_x    <= in_data;
      s1_msb  <= lzc_msb;
      s1_zero <= lzc_zero;
    end
  end

endmodule

// File: doc/int2float_pipe.md
INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 11, meaning unsigned integer input width.
REQ-002 SHALL have parameter EXP_W, default 3, meaning exponent field width.
REQ-003 SHALL have parameter MAN_W, default 4, meaning mantissa field width; the mantissa has no hidden bit.
REQ-004 SHALL have clock `clk`, input, 1, one clock domain; all flops rise on it.
REQ-005 SHALL have reset `rst_n`, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have `in_valid`, input, 1, meaning the input word is presented.
REQ-007 SHALL have `in_ready`, output, 1, meaning the block accepts the word this cycle.
REQ-008 SHALL have `in_data`, input, IN_W, the unsigned integer.
REQ-009 SHALL have `out_valid`, output, 1, meaning the result is presented.
REQ-010 SHALL have `out_ready`, input, 1, meaning downstream accepts the result.
REQ-011 SHALL have `out_data`, output, EXP_W+MAN_W, the result {exp, man} with exp in the MSBs.

Function
REQ-012 SHALL encode as follows: for x < 2^MAN_W, exp=0 and man=x; otherwise, with p = MSB index of x, exp = p-MAN_W+1 and man = x[p -: MAN_W], representing man*2^exp.
REQ-013 SHALL be a 2-stage pipeline, with stage 1 = leading-one detect plus capture, and stage 2 = shift, round and pack.
REQ-014 SHALL have a latency of exactly 2 cycles from the in_valid&&in_ready edge to out_valid, when not stalled.
REQ-015 SHALL sustain a throughput of 1 word/cycle while out_ready=1.
REQ-016 SHALL transfer data only on cycles where valid&&ready on the respective side.
REQ-017 SHALL drive in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, when a stage is stalled, keep its register contents and neither drop nor duplicate any word.
REQ-020 SHALL produce exp=0 and man=0 for x=0.
REQ-021 SHALL, if rounding carries out of the mantissa, set man=2^(MAN_W-1) and increment exp.
REQ-022 SHALL, if exp would exceed 2^EXP_W-1, saturate out_data to all ones.
REQ-023 SHALL treat the condition IN_W > MAN_W + 2^EXP_W - 1 as an elaboration error, via a static assertion.

Reset
REQ-024 SHALL, while rst_n=0, clear s1_valid, s2_valid and out_valid to 0, force out_data to 0 and drive in_ready to 1.
REQ-025 SHALL discard all in-flight words on a reset asserted mid-operation, with no output after release until new input arrives.
REQ-026 SHALL leave data-path registers other than out_data unreset.

Configuration
REQ-027 SHALL, when INT2FLOAT_RNE_EN is defined, round discarded bits to nearest-even: up if remainder > half, or if remainder = half and man LSB = 1.
REQ-028 SHALL, when INT2FLOAT_RNE_EN is undefined, truncate; the carry and saturation logic of REQ-021/022 SHALL then be absent, with identical latency and handshake.

Structure
REQ-029 SHALL place default widths, the derived constant OUT_W = EXP_W+MAN_W, and a packed struct type for {exp, man} in package int2float_pkg.
REQ-030 SHALL implement leading-one detection as sub-module int2float_lzc, parametrised by IN_W, outputting the MSB index and an all-zero flag.

Verification (defaults 11/3/4)
REQ-031 SHALL cover: inputs 0, 13 and 16, back-to-back, with out_ready=1 -> out_data 0x00, 0x0D, 0x18 on cycles 2, 3 and 4.
REQ-032 SHALL cover: input 0x098 -> 0x49 with truncation; 0x4A with RNE (tie, odd LSB).
REQ-033 SHALL cover: input 0x7FF -> 0x7F in both modes, the RNE case saturating; input 0x0B4 -> 0x4B in both modes.
REQ-034 SHALL cover: a stream of 6 words with out_ready held 0 for 5 cycles -> in_ready=0 after 2 accepted words, out_data held, and all 6 results in order after release.
REQ-035 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately and no stale output after release.
REQ-036 SHALL cover: 10k random words with random in_valid/out_ready -> scoreboard matches the REQ-012 reference model, with no loss or reordering.
